router_input_lock_ctrl: RTL and testbench

ROUTER_INPUT_LOCK_CTRL -- requirements
Module: router_input_lock_ctrl

---
 rtl/router_input_lock_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_router_input_lock_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/router_input_lock_ctrl.sv
// Router input port: flit FIFO plus the packet-lock FSM that requests an output,
// holds it for the whole packet and drops packets or orphan flits it cannot route.
module router_input_lock_ctrl #(
  parameter int FLIT_W  = 34,
  parameter int DEST_W  = 3,
  parameter int NUM_OUT = 5,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLIT_W-1:0]  in_flit,
  output logic [NUM_OUT-1:0] out_req,
  input  logic [NUM_OUT-1:0] out_grant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FLIT_W-1:0]  out_flit,
  output logic               lock,
  output logic [7:0]         drop_cnt,
  output logic [7:0]         orphan_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [31:0] NUM_OUT_U = NUM_OUT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_DROP   = 2'd3
  } state_e;

  function automatic logic [NUM_OUT-1:0] dest_onehot(input logic [DEST_W-1:0] d);
    logic [NUM_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (32'(d) == 32'(i)) v[i] = 1'b1;
      else                  v[i] = 1'b0;
    end
    return v;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic inc);
    logic [7:0] r;
    if (inc && (c != 8'hFF)) r = c + 8'd1;
    else                     r = c;
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic [FLIT_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic                in_ready_q, in_ready_d;
  logic [NUM_OUT-1:0]  out_req_q, out_req_d;
  logic                lock_q, lock_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d, orphan_cnt_q, orphan_cnt_d;

  logic                push, pop, not_empty, dest_ok, grant_sel, drop_inc, orphan_inc;
  logic [FLIT_W-1:0]   head_flit;
  logic [1:0]          head_type;
  logic [DEST_W-1:0]   head_dest;

  assign head_flit = mem_q[rd_ptr_q];
  assign head_type = head_flit[FLIT_W-1 -: 2];
  assign head_dest = head_flit[DEST_W-1:0];
  assign not_empty = (count_q != '0);
  assign dest_ok   = (32'(head_dest) < NUM_OUT_U);
  assign grant_sel = |(out_grant & dest_onehot(dest_q));
  // in_ready_q always mirrors !full, so a full FIFO refuses pushes even on a pop cycle
  assign push      = in_valid & in_ready_q;

  // type[0] marks a head (01/11), type[1] marks a tail (10/11)
  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    pop        = 1'b0;
    drop_inc   = 1'b0;
    orphan_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (not_empty) begin
          if (head_type[0]) begin
            if (dest_ok) begin
              state_d = ST_REQ;
              dest_d  = head_dest;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            pop        = 1'b1;
            orphan_inc = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (grant_sel) state_d = ST_LOCKED;
        else           state_d = ST_REQ;
      end
      ST_LOCKED: begin
        if (not_empty && out_ready) begin
          pop = 1'b1;
          if (head_type[1]) state_d = ST_IDLE;
          else              state_d = ST_LOCKED;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_DROP: begin
        if (not_empty) begin
          pop = 1'b1;
          if (head_type[1]) begin
            state_d  = ST_IDLE;
            drop_inc = 1'b1;
          end else begin
            state_d = ST_DROP;
          end
        end else begin
          state_d = ST_DROP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_ptr_d     = rd_ptr_q + AW'(pop);
    wr_ptr_d     = wr_ptr_q + AW'(push);
    count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
    in_ready_d   = (count_d != DEPTH_C);
    lock_d       = (state_d == ST_LOCKED);
    if ((state_d == ST_REQ) || (state_d == ST_LOCKED)) out_req_d = dest_onehot(dest_d);
    else                                               out_req_d = '0;
    drop_cnt_d   = sat_inc(drop_cnt_q, drop_inc);
    orphan_cnt_d = sat_inc(orphan_cnt_q, orphan_inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dest_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      in_ready_q   <= 1'b0;
      out_req_q    <= '0;
      lock_q       <= 1'b0;
      drop_cnt_q   <= 8'd0;
      orphan_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      in_ready_q   <= in_ready_d;
      out_req_q    <= out_req_d;
      lock_q       <= lock_d;
      drop_cnt_q   <= drop_cnt_d;
      orphan_cnt_q <= orphan_cnt_d;
    end
  end

  // Flit storage carries no control meaning, so it is left out of reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_flit;
  end

  assign in_ready   = in_ready_q;
  assign out_req    = out_req_q;
  assign lock       = lock_q;
  assign out_valid  = (state_q == ST_LOCKED) && not_empty;
  assign out_flit   = head_flit;
  assign drop_cnt   = drop_cnt_q;
  assign orphan_cnt = orphan_cnt_q;

endmodule

// File: tb/tb_router_input_lock_ctrl.sv
// Directed bench for router_input_lock_ctrl: per-scenario tasks with inline checks.
module tb_router_input_lock_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [33:0] in_flit;
  logic [4:0]  out_req;
  logic [4:0]  out_grant;
  logic        out_valid;
  logic        out_ready;
  logic [33:0] out_flit;
  logic        lock;
  logic [7:0]  drop_cnt;
  logic [7:0]  orphan_cnt;

  int total = 0;
  int bad   = 0;

  logic [33:0] src_q[$];
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];
  int          req_cyc;
  int          lock_cyc;
  logic [4:0]  req_or;

  router_input_lock_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .out_req(out_req), .out_grant(out_grant), .out_valid(out_valid), .out_ready(out_ready),
    .out_flit(out_flit), .lock(lock), .drop_cnt(drop_cnt), .orphan_cnt(orphan_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] mk(input logic [1:0] t, input logic [7:0] tag, input logic [2:0] d);
    return {t, 16'h0000, tag, 5'b00000, d};
  endfunction

  task automatic clear_mon();
    got_q.delete();
    req_cyc  = 0;
    lock_cyc = 0;
    req_or   = 5'b00000;
  endtask

  // One clock: drive the next source flit, record outputs, advance past the edge
  task automatic step();
    logic acc;
    in_valid = (src_q.size() != 0);
    in_flit  = in_valid ? src_q[0] : 34'h0;
    if (out_valid && out_ready) got_q.push_back(out_flit);
    if (lock) lock_cyc++;
    if (out_req != 5'b00000) begin
      req_cyc++;
      req_or = req_or | out_req;
    end
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) void'(src_q.pop_front());
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_flit = 34'h0; out_grant = 5'b00000; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_req !== 5'b00000) begin bad++; $display("FAIL reset_out_req got=%b exp=00000", out_req); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (lock !== 1'b0) begin bad++; $display("FAIL reset_lock got=%b exp=0", lock); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (drop_cnt !== 8'd0 || orphan_cnt !== 8'd0) begin bad++; $display("FAIL reset_counts drop=%0d orphan=%0d exp=0/0", drop_cnt, orphan_cnt); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic_packet();
    clear_mon();
    out_ready = 1'b1; out_grant = 5'b00100;
    exp_q = '{mk(2'b01, 8'h01, 3'd2), mk(2'b00, 8'h02, 3'd0), mk(2'b10, 8'h03, 3'd0)};
    src_q = exp_q;
    step();
    total++; if (out_req !== 5'b00000) begin bad++; $display("FAIL basic_req_early got=%b exp=00000", out_req); end
    step();
    total++; if (out_req !== 5'b00100) begin bad++; $display("FAIL basic_req got=%b exp=00100", out_req); end
    total++; if (lock !== 1'b0) begin bad++; $display("FAIL basic_lock_before_grant got=%b exp=0", lock); end
    repeat (10) step();
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL basic_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_flit%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (lock_cyc != 3) begin bad++; $display("FAIL basic_lock_cycles got=%0d exp=3", lock_cyc); end
    total++; if (lock !== 1'b0 || out_req !== 5'b00000) begin bad++; $display("FAIL basic_release lock=%b req=%b exp=0/00000", lock, out_req); end
  endtask

  task automatic test_delayed_grant();
    clear_mon();
    out_ready = 1'b1; out_grant = 5'b00000;
    exp_q = '{mk(2'b11, 8'h10, 3'd0)};
    src_q = exp_q;
    repeat (2) step();
    total++; if (out_req !== 5'b00001) begin bad++; $display("FAIL dg_req got=%b exp=00001", out_req); end
    out_grant = 5'b11110;
    repeat (5) step();
    total++; if (lock !== 1'b0 || out_req !== 5'b00001) begin bad++; $display("FAIL dg_wrong_grant lock=%b req=%b exp=0/00001", lock, out_req); end
    out_grant = 5'b00001;
    step();
    total++; if (lock !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL dg_locked lock=%b valid=%b exp=1/1", lock, out_valid); end
    total++; if (out_flit !== exp_q[0]) begin bad++; $display("FAIL dg_flit got=%h exp=%h", out_flit, exp_q[0]); end
    step();
    total++; if (lock !== 1'b0 || out_req !== 5'b00000 || out_valid !== 1'b0) begin bad++; $display("FAIL dg_release lock=%b req=%b valid=%b exp=0/00000/0", lock, out_req, out_valid); end
    repeat (2) step();
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL dg_count got=%0d exp=1", got_q.size()); end
    total++; if (lock_cyc != 1) begin bad++; $display("FAIL dg_lock_cycles got=%0d exp=1", lock_cyc); end
    total++; if (req_cyc < 5) begin bad++; $display("FAIL dg_req_cycles got=%0d exp>=5", req_cyc); end
    out_grant = 5'b00000;
  endtask

  task automatic test_drop();
    clear_mon();
    out_ready = 1'b1; out_grant = 5'b11111;
    exp_q = '{mk(2'b11, 8'h26, 3'd4)};
    src_q = '{mk(2'b01, 8'h20, 3'd6), mk(2'b00, 8'h21, 3'd0), mk(2'b00, 8'h22, 3'd0),
              mk(2'b10, 8'h23, 3'd0), mk(2'b11, 8'h25, 3'd5), exp_q[0]};
    repeat (20) step();
    total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL drop_cnt got=%0d exp=2", drop_cnt); end
    total++; if (orphan_cnt !== 8'd0) begin bad++; $display("FAIL drop_orphan got=%0d exp=0", orphan_cnt); end
    total++; if (req_or !== 5'b10000) begin bad++; $display("FAIL drop_req_seen got=%b exp=10000", req_or); end
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL drop_xfers got=%0d exp=1", got_q.size()); end
    if (got_q.size() == 1) begin
      total++; if (got_q[0] !== exp_q[0]) begin bad++; $display("FAIL drop_valid_flit got=%h exp=%h", got_q[0], exp_q[0]); end
    end
    total++; if (src_q.size() != 0) begin bad++; $display("FAIL drop_src_left got=%0d exp=0", src_q.size()); end
    out_grant = 5'b00000;
  endtask

  task automatic test_orphan();
    clear_mon();
    out_ready = 1'b1; out_grant = 5'b00010;
    exp_q = '{mk(2'b01, 8'h31, 3'd1), mk(2'b00, 8'h32, 3'd7), mk(2'b10, 8'h33, 3'd3)};
    src_q = '{mk(2'b00, 8'h30, 3'd1)};
    foreach (exp_q[i]) src_q.push_back(exp_q[i]);
    repeat (15) step();
    total++; if (orphan_cnt !== 8'd1) begin bad++; $display("FAIL orphan_cnt got=%0d exp=1", orphan_cnt); end
    total++; if (req_or !== 5'b00010) begin bad++; $display("FAIL orphan_req got=%b exp=00010", req_or); end
    total++; if (got_q.size() != 3) begin bad++; $display("FAIL orphan_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL orphan_flit%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    out_grant = 5'b00000;
  endtask

  task automatic test_back_pressure();
    clear_mon();
    out_ready = 1'b0; out_grant = 5'b01000;
    exp_q = '{mk(2'b01, 8'h40, 3'd3), mk(2'b00, 8'h41, 3'd0), mk(2'b01, 8'h42, 3'd0),
              mk(2'b00, 8'h43, 3'd0), mk(2'b00, 8'h44, 3'd0), mk(2'b00, 8'h45, 3'd0),
              mk(2'b10, 8'h46, 3'd0)};
    src_q = exp_q;
    repeat (10) step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    total++; if (src_q.size() != 3) begin bad++; $display("FAIL bp_accepted left=%0d exp=3", src_q.size()); end
    total++; if (lock !== 1'b1 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_locked lock=%b valid=%b exp=1/1", lock, out_valid); end
    out_ready = 1'b1;
    repeat (15) step();
    total++; if (got_q.size() != 7) begin bad++; $display("FAIL bp_count got=%0d exp=7", got_q.size()); end
    for (int i = 0; i < 7 && i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_flit%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    total++; if (req_or !== 5'b01000) begin bad++; $display("FAIL bp_no_reroute got=%b exp=01000", req_or); end
    total++; if (lock !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", lock); end
    out_grant = 5'b00000;
  endtask

  task automatic test_saturation();
    clear_mon();
    out_ready = 1'b1; out_grant = 5'b00000;
    for (int i = 0; i < 260; i++) src_q.push_back(mk(2'b10, 8'(i), 3'd0));
    repeat (300) step();
    total++; if (orphan_cnt !== 8'd255) begin bad++; $display("FAIL sat_orphan got=%0d exp=255", orphan_cnt); end
    total++; if (src_q.size() != 0) begin bad++; $display("FAIL sat_src_left got=%0d exp=0", src_q.size()); end
  endtask

  task automatic test_reset_mid_packet();
    clear_mon();
    out_ready = 1'b0; out_grant = 5'b00100;
    src_q = '{mk(2'b01, 8'h50, 3'd2), mk(2'b00, 8'h51, 3'd0)};
    repeat (5) step();
    total++; if (lock !== 1'b1) begin bad++; $display("FAIL rm_locked got=%b exp=1", lock); end
    reset = 1'b1;
    step();
    total++; if (lock !== 1'b0 || out_req !== 5'b00000 || out_valid !== 1'b0) begin bad++; $display("FAIL rm_cleared lock=%b req=%b valid=%b exp=0/00000/0", lock, out_req, out_valid); end
    total++; if (in_ready !== 1'b0 || drop_cnt !== 8'd0 || orphan_cnt !== 8'd0) begin bad++; $display("FAIL rm_state rdy=%b drop=%0d orphan=%0d exp=0/0/0", in_ready, drop_cnt, orphan_cnt); end
    reset = 1'b0;
    out_ready = 1'b1;
    clear_mon();
    src_q = '{mk(2'b00, 8'h52, 3'd0), mk(2'b10, 8'h53, 3'd0)};
    repeat (8) step();
    total++; if (orphan_cnt !== 8'd2) begin bad++; $display("FAIL rm_orphans got=%0d exp=2", orphan_cnt); end
    total++; if (req_or !== 5'b00000 || got_q.size() != 0 || lock !== 1'b0) begin bad++; $display("FAIL rm_quiet req=%b xfers=%0d lock=%b exp=00000/0/0", req_or, got_q.size(), lock); end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_delayed_grant();
    test_drop();
    test_orphan();
    test_back_pressure();
    test_saturation();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
